mul_div: RTL and testbench

MUL_DIV -- requirements
Module: mul_div

---
 rtl/mul_div.sv | 191 +++++++++++++++++++
 tb/tb_mul_div.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div.sv
// mul_div: 32-bit iterative multiplier/divider.
// MULU/MULS use radix-2 shift-add and DIVU/DIVS use restoring shift-subtract,
// both on operand magnitudes. Signs are applied in a final fix-up step.
// An operation takes 34 cycles from the start cycle to the done pulse.
// A divide by zero finishes one cycle after the start cycle.

module mul_div (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  op,
   input  logic [31:0] aRegister,
   input  logic [31:0] bRegister,
   output logic        busy,
   output logic        done,
   output logic [31:0] resultHi,
   output logic [31:0] resultLo,
   output logic        divByZero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic [4:0]  r_count;
   logic        r_isDiv;
   logic        r_negLo;
   logic        r_negHi;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_operB;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_resultHi;
   logic [31:0] r_resultLo;
   logic        r_divByZero;

   logic        w_isSigned;
   logic        w_isDiv;
   logic        w_signA;
   logic        w_signB;
   logic [31:0] w_magA;
   logic [31:0] w_magB;
   logic [32:0] w_mulSum;
   logic [32:0] w_divShift;
   logic        w_divGe;
   logic [31:0] w_divDiff;
   logic [31:0] w_nextHi;
   logic [31:0] w_nextLo;
   logic [63:0] w_prodNeg;
   logic [31:0] w_fixHi;
   logic [31:0] w_fixLo;

   // Operand decode at the start edge: signed ops work on magnitudes.
   // The magnitude of 0x80000000 is 0x80000000 as an unsigned value,
   // which keeps the most negative operand exact.
   always_comb begin
      w_isSigned = op[0];
      w_isDiv    = op[1];
      w_signA    = w_isSigned & aRegister[31];
      w_signB    = w_isSigned & bRegister[31];
      w_magA     = w_signA ? (32'd0 - aRegister) : aRegister;
      w_magB     = w_signB ? (32'd0 - bRegister) : bRegister;
   end

   // One iteration step. MUL keeps {hi,lo} as the partial product with the
   // multiplier shifting out of lo; DIV keeps the partial remainder in hi and
   // shifts dividend bits out of lo while quotient bits shift in.
   always_comb begin
      w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operB} : 33'd0);
      w_divShift = {r_hi, r_lo[31]};
      w_divGe    = (w_divShift >= {1'b0, r_operB});
      w_divDiff  = w_divShift[31:0] - r_operB;
      if (r_isDiv) begin
         w_nextHi = w_divGe ? w_divDiff : w_divShift[31:0];
         w_nextLo = {r_lo[30:0], w_divGe};
      end else begin
         w_nextHi = w_mulSum[32:1];
         w_nextLo = {w_mulSum[0], r_lo[31:1]};
      end
   end

   // Sign fix-up: full 64-bit negate for a product, independent 32-bit
   // negates of quotient and remainder for a divide.
   always_comb begin
      w_prodNeg = 64'd0 - {r_hi, r_lo};
      w_fixHi   = r_hi;
      w_fixLo   = r_lo;
      if (r_isDiv) begin
         if (r_negLo) w_fixLo = 32'd0 - r_lo;
         if (r_negHi) w_fixHi = 32'd0 - r_hi;
      end else if (r_negLo) begin
         w_fixHi = w_prodNeg[63:32];
         w_fixLo = w_prodNeg[31:0];
      end
   end

   // Control FSM and datapath registers; reset beats flush, flush beats start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_count     <= 5'd0;
         r_isDiv     <= 1'b0;
         r_negLo     <= 1'b0;
         r_negHi     <= 1'b0;
         r_hi        <= 32'd0;
         r_lo        <= 32'd0;
         r_operB     <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_resultHi  <= 32'd0;
         r_resultLo  <= 32'd0;
         r_divByZero <= 1'b0;
      end else if (flush) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_isDiv <= w_isDiv;
                  if (w_isDiv && (bRegister == 32'd0)) begin
                     r_state     <= DONE;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_resultLo  <= 32'hFFFF_FFFF;
                     r_resultHi  <= aRegister;
                     r_divByZero <= 1'b1;
                  end else begin
                     r_state <= CALC;
                     r_busy  <= 1'b1;
                     r_count <= 5'd31;
                     r_hi    <= 32'd0;
                     if (w_isDiv) begin
                        r_lo    <= w_magA;
                        r_operB <= w_magB;
                        r_negLo <= w_signA ^ w_signB;
                        r_negHi <= w_signA;
                     end else begin
                        r_lo    <= w_magB;
                        r_operB <= w_magA;
                        r_negLo <= w_signA ^ w_signB;
                        r_negHi <= w_signA ^ w_signB;
                     end
                  end
               end
            end
            CALC: begin
               r_hi <= w_nextHi;
               r_lo <= w_nextLo;
               if (r_count == 5'd0) begin
                  r_state <= FIX;
               end else begin
                  r_count <= r_count - 5'd1;
               end
            end
            FIX: begin
               r_state     <= DONE;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
               r_resultHi  <= w_fixHi;
               r_resultLo  <= w_fixLo;
               r_divByZero <= 1'b0;
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign resultHi  = r_resultHi;
   assign resultLo  = r_resultLo;
   assign divByZero = r_divByZero;

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: directed self-checking bench for mul_div.
// Inputs are driven and outputs sampled on the falling edge.

module tb_mul_div;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [1:0]  op;
   logic [31:0] aRegister;
   logic [31:0] bRegister;
   logic        busy;
   logic        done;
   logic [31:0] resultHi;
   logic [31:0] resultLo;
   logic        divByZero;

   int checks;
   int errors;

   localparam logic [1:0] MULU = 2'b00;
   localparam logic [1:0] MULS = 2'b01;
   localparam logic [1:0] DIVU = 2'b10;
   localparam logic [1:0] DIVS = 2'b11;

   mul_div dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .flush     (flush),
      .op        (op),
      .aRegister (aRegister),
      .bRegister (bRegister),
      .busy      (busy),
      .done      (done),
      .resultHi  (resultHi),
      .resultLo  (resultLo),
      .divByZero (divByZero)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one start cycle, then scramble the operands so any late capture shows up.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start     = 1'b1;
      op        = o;
      aRegister = a;
      bRegister = b;
      @(negedge clk);
      start     = 1'b0;
      op        = ~o;
      aRegister = 32'h5A5A_1234;
      bRegister = 32'h0000_0000;
   endtask

   // Wait (bounded) for done; latency counts cycles from the start cycle.
   task automatic waitDone(output int lat, output logic sawBusy);
      lat     = 1;
      sawBusy = (busy === 1'b1);
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) sawBusy = 1'b1;
      end
   endtask

   task automatic test_reset;
      int lat;
      logic sb;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, divByZero} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags busy/done/dbz=%b expected 000", {busy, done, divByZero});
      end
      checks++;
      if ({resultHi, resultLo} !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_results got %h expected 0", {resultHi, resultLo});
      end
      // first start accepted on the very first edge with reset low
      reset     = 1'b0;
      start     = 1'b1;
      op        = MULU;
      aRegister = 32'd6;
      bRegister = 32'd7;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL first_start busy=%b expected 1", busy);
      end
      waitDone(lat, sb);
      checks++;
      if ({resultHi, resultLo} !== 64'd42 || lat != 34) begin
         errors++;
         $display("[TB] FAIL first_mul got %h lat %0d expected 2a lat 34", {resultHi, resultLo}, lat);
      end
   endtask

   task automatic test_mulu;
      int lat;
      logic sb;
      applyStimulus(MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone(lat, sb);
      checks++;
      if (lat != 34) begin
         errors++;
         $display("[TB] FAIL mulu_latency got %0d expected 34", lat);
      end
      checks++;
      if ({resultHi, resultLo} !== 64'hFFFF_FFFE_0000_0001 || divByZero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mulu_result got %h dbz %b expected fffffffe00000001 dbz 0",
                  {resultHi, resultLo}, divByZero);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {resultHi, resultLo} !== 64'hFFFF_FFFE_0000_0001) begin
         errors++;
         $display("[TB] FAIL mulu_hold done %b busy %b result %h expected 0 0 fffffffe00000001",
                  done, busy, {resultHi, resultLo});
      end
   endtask

   task automatic test_muls;
      int lat;
      logic sb;
      applyStimulus(MULS, 32'hFFFF_FFFD, 32'h0000_0005);
      waitDone(lat, sb);
      checks++;
      if ({resultHi, resultLo} !== 64'hFFFF_FFFF_FFFF_FFF1 || lat != 34) begin
         errors++;
         $display("[TB] FAIL muls_neg got %h lat %0d expected fffffffffffffff1 lat 34", {resultHi, resultLo}, lat);
      end
      applyStimulus(MULS, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
      waitDone(lat, sb);
      checks++;
      if ({resultHi, resultLo} !== 64'h0000_0000_0000_002A) begin
         errors++;
         $display("[TB] FAIL muls_negneg got %h expected 2a", {resultHi, resultLo});
      end
      applyStimulus(MULS, 32'h8000_0000, 32'h8000_0000);
      waitDone(lat, sb);
      checks++;
      if ({resultHi, resultLo} !== 64'h4000_0000_0000_0000) begin
         errors++;
         $display("[TB] FAIL muls_minmin got %h expected 4000000000000000", {resultHi, resultLo});
      end
   endtask

   task automatic test_div;
      int lat;
      logic sb;
      applyStimulus(DIVU, 32'd100, 32'd7);
      waitDone(lat, sb);
      checks++;
      if (resultLo !== 32'd14 || resultHi !== 32'd2 || divByZero !== 1'b0 || lat != 34) begin
         errors++;
         $display("[TB] FAIL divu got q %h r %h dbz %b lat %0d expected q e r 2 dbz 0 lat 34",
                  resultLo, resultHi, divByZero, lat);
      end
      applyStimulus(DIVS, 32'hFFFF_FFF9, 32'h0000_0002);
      waitDone(lat, sb);
      checks++;
      if (resultLo !== 32'hFFFF_FFFD || resultHi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("[TB] FAIL divs_negA got q %h r %h expected q fffffffd r ffffffff", resultLo, resultHi);
      end
      applyStimulus(DIVS, 32'h0000_0007, 32'hFFFF_FFFE);
      waitDone(lat, sb);
      checks++;
      if (resultLo !== 32'hFFFF_FFFD || resultHi !== 32'h0000_0001) begin
         errors++;
         $display("[TB] FAIL divs_negB got q %h r %h expected q fffffffd r 1", resultLo, resultHi);
      end
      applyStimulus(DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(lat, sb);
      checks++;
      if (resultLo !== 32'h8000_0000 || resultHi !== 32'h0000_0000 || divByZero !== 1'b0) begin
         errors++;
         $display("[TB] FAIL divs_overflow got q %h r %h dbz %b expected q 80000000 r 0 dbz 0",
                  resultLo, resultHi, divByZero);
      end
   endtask

   task automatic test_div_zero;
      int lat;
      logic sb;
      applyStimulus(DIVU, 32'h0000_0064, 32'h0000_0000);
      waitDone(lat, sb);
      checks++;
      if (lat != 1 || sb !== 1'b0) begin
         errors++;
         $display("[TB] FAIL divzero_timing lat %0d busySeen %b expected lat 1 busySeen 0", lat, sb);
      end
      checks++;
      if (resultLo !== 32'hFFFF_FFFF || resultHi !== 32'h0000_0064 || divByZero !== 1'b1) begin
         errors++;
         $display("[TB] FAIL divzero_result got q %h r %h dbz %b expected q ffffffff r 64 dbz 1",
                  resultLo, resultHi, divByZero);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || divByZero !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL divzero_hold done %b dbz %b busy %b expected 0 1 0", done, divByZero, busy);
      end
      applyStimulus(DIVS, 32'h8000_0000, 32'h0000_0000);
      waitDone(lat, sb);
      checks++;
      if (lat != 1 || resultHi !== 32'h8000_0000 || resultLo !== 32'hFFFF_FFFF || divByZero !== 1'b1) begin
         errors++;
         $display("[TB] FAIL divzero_signed lat %0d r %h q %h dbz %b expected lat 1 r 80000000 q ffffffff dbz 1",
                  lat, resultHi, resultLo, divByZero);
      end
   endtask

   task automatic test_start_ignored;
      int lat;
      logic sb;
      applyStimulus(MULU, 32'd3, 32'd4);
      repeat (4) @(negedge clk);
      start     = 1'b1;
      op        = DIVU;
      aRegister = 32'd9;
      bRegister = 32'd0;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if ({resultHi, resultLo} !== 64'd12 || divByZero !== 1'b0 || lat != 28) begin
         errors++;
         $display("[TB] FAIL start_ignored got %h dbz %b wait %0d expected c dbz 0 wait 28",
                  {resultHi, resultLo}, divByZero, lat);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL no_queue busy %b done %b expected 0 0", busy, done);
      end
   endtask

   task automatic test_abort_reset;
      int lat;
      logic sb;
      applyStimulus(MULU, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({busy, done, divByZero} !== 3'b000 || {resultHi, resultLo} !== 64'd0) begin
         errors++;
         $display("[TB] FAIL abort_reset flags %b result %h expected 000 0",
                  {busy, done, divByZero}, {resultHi, resultLo});
      end
      applyStimulus(DIVU, 32'd100, 32'd7);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_after_reset busy %b expected 1", busy);
      end
      waitDone(lat, sb);
      checks++;
      if (resultLo !== 32'd14 || resultHi !== 32'd2 || lat != 34) begin
         errors++;
         $display("[TB] FAIL after_reset_div q %h r %h lat %0d expected e 2 34", resultLo, resultHi, lat);
      end
   endtask

   task automatic test_abort_flush;
      int lat;
      int doneSeen;
      logic sb;
      applyStimulus(MULU, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || resultLo !== 32'd14 || resultHi !== 32'd2) begin
         errors++;
         $display("[TB] FAIL abort_flush busy %b done %b q %h r %h expected 0 0 e 2",
                  busy, done, resultLo, resultHi);
      end
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) doneSeen++;
      end
      checks++;
      if (doneSeen != 0) begin
         errors++;
         $display("[TB] FAIL flush_quiet activity %0d cycles expected 0", doneSeen);
      end
      // flush and start on the same edge: flush wins
      @(negedge clk);
      flush     = 1'b1;
      start     = 1'b1;
      op        = MULU;
      aRegister = 32'd2;
      bRegister = 32'd3;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_priority busy %b done %b expected 0 0", busy, done);
      end
      applyStimulus(MULS, 32'hFFFF_FFFF, 32'h0000_0001);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_after_flush busy %b expected 1", busy);
      end
      waitDone(lat, sb);
      checks++;
      if ({resultHi, resultLo} !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 34) begin
         errors++;
         $display("[TB] FAIL after_flush_mul got %h lat %0d expected ffffffffffffffff 34",
                  {resultHi, resultLo}, lat);
      end
   endtask

   // Run the scenarios in order and report.
   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      flush     = 1'b0;
      op        = MULU;
      aRegister = 32'd0;
      bRegister = 32'd0;
      test_reset;
      test_mulu;
      test_muls;
      test_div;
      test_div_zero;
      test_start_ignored;
      test_abort_reset;
      test_abort_flush;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
